lock_gen: RTL and testbench

LOCK_GEN -- requirements
Module: lock_gen

---
 rtl/lock_pkg.sv | 42 ++++
 rtl/lock_keysync.sv | 67 ++++++
 rtl/lock_gen.sv | 218 +++++++++++++++++++++
 tb/tb_lock_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock: FSM states, key codes and the
// hex-to-seven-segment encoder used by the display drivers.
package lock_pkg;

  typedef enum logic [2:0] {
    StLocked,
    StEntry,
    StOpen,
    StProgram,
    StAlarm
  } lock_state_e;

  localparam int unsigned NumPb    = 21;
  localparam int unsigned KeyEnter = 16;
  localparam int unsigned KeyClear = 17;
  localparam int unsigned KeyProg  = 18;

  // Segment order {dp, g, f, e, d, c, b, a}, active high, decimal point unused.
  function automatic logic [7:0] hex7seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h07;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lock_keysync.sv
// Push-button front end: registers pb, detects rising edges and picks the
// single key that acts this cycle (clear > enter > program > lowest digit).
// The program key only participates when LOCK_PROGRAM_EN is defined.
module lock_keysync
  import lock_pkg::*;
(
  input  logic             hz100_i,
  input  logic             reset_i,
  input  logic [NumPb-1:0] pb_i,
  output logic             key_valid_o,
  output logic [4:0]       key_code_o
);

  localparam int unsigned UsedKeys = 19;

  logic [UsedKeys-1:0] pb_q;
  logic [UsedKeys-1:0] pb_prev_q;
  logic [UsedKeys-1:0] rise;

  logic unused_pb;
  assign unused_pb = ^pb_i[NumPb-1:UsedKeys];

  // Input register followed by a one-cycle history for edge detection.
  always_ff @(posedge hz100_i) begin
    if (reset_i) begin
      pb_q      <= '0;
      pb_prev_q <= '0;
    end else begin
      pb_q      <= pb_i[UsedKeys-1:0];
      pb_prev_q <= pb_q;
    end
  end

  assign rise = pb_q & ~pb_prev_q;

`ifndef LOCK_PROGRAM_EN
  logic unused_prog;
  assign unused_prog = rise[KeyProg];
`endif

  // Priority encode so exactly one key acts per cycle.
  always_comb begin
    key_valid_o = 1'b0;
    key_code_o  = '0;
    if (rise[KeyClear]) begin
      key_valid_o = 1'b1;
      key_code_o  = 5'(KeyClear);
    end else if (rise[KeyEnter]) begin
      key_valid_o = 1'b1;
      key_code_o  = 5'(KeyEnter);
`ifdef LOCK_PROGRAM_EN
    end else if (rise[KeyProg]) begin
      key_valid_o = 1'b1;
      key_code_o  = 5'(KeyProg);
`endif
    end else begin
      // Descending scan so the lowest-numbered digit wins.
      for (int k = 15; k >= 0; k--) begin
        if (rise[k]) begin
          key_valid_o = 1'b1;
          key_code_o  = 5'(k);
        end
      end
    end
  end

endmodule

// File: rtl/lock_gen.sv
// Keypad combination lock. Digits shift into an entry buffer (digit 0 is the
// most recent), enter checks the code, repeated failures trigger a timed
// lockout. Define LOCK_PROGRAM_EN to allow reprogramming the code from OPEN.
module lock_gen
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN      = 4,
  parameter logic [31:0] CODE_DEFAULT  = 32'h0000_1234,
  parameter int unsigned MAX_TRIES     = 3,
  parameter int unsigned LOCKOUT_TICKS = 500
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  output logic [7:0]  ss7,
  output logic [7:0]  ss6,
  output logic [7:0]  ss5,
  output logic [7:0]  ss4,
  output logic [7:0]  ss3,
  output logic [7:0]  ss2,
  output logic [7:0]  ss1,
  output logic [7:0]  ss0,
  output logic [7:0]  left,
  output logic [7:0]  right,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned BufW  = 4 * CODE_LEN;
  localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TickW = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;
  localparam logic [BufW-1:0] CodeInit = CODE_DEFAULT[BufW-1:0];

  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_digit;
  logic        key_enter;
  logic        key_clear;

  lock_state_e      state_q, state_d;
  logic [BufW-1:0]  buf_q, buf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [FailW-1:0] fail_q, fail_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [BufW-1:0]  code_cur;
  logic [BufW-1:0]  buf_shift;
  logic [FailW-1:0] fail_inc;
  logic             cnt_full;
  logic [7:0]       ss_arr [8];
  logic [31:0]      buf_ext;

  lock_keysync u_keysync (
    .hz100_i     (hz100),
    .reset_i     (reset),
    .pb_i        (pb),
    .key_valid_o (key_valid),
    .key_code_o  (key_code)
  );

  assign key_digit = key_valid & ~key_code[4];
  assign key_enter = key_valid & (key_code == 5'(KeyEnter));
  assign key_clear = key_valid & (key_code == 5'(KeyClear));
  assign cnt_full  = (cnt_q == CntW'(CODE_LEN));
  assign fail_inc  = fail_q + 1'b1;

`ifdef LOCK_PROGRAM_EN
  logic             key_prog;
  logic [BufW-1:0]  code_q, code_d;
  assign key_prog = key_valid & (key_code == 5'(KeyProg));
  assign code_cur = code_q;
`else
  assign code_cur = CodeInit;
`endif

  // Next-state logic: key strobes drive entry and unlock, the tick counter times lockout.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    tick_d    = tick_q;
`ifdef LOCK_PROGRAM_EN
    code_d    = code_q;
`endif
    buf_shift      = buf_q << 4;
    buf_shift[3:0] = key_code[3:0];
    case (state_q)
      StLocked: begin
        if (key_digit) begin
          buf_d   = buf_shift;
          cnt_d   = CntW'(1);
          state_d = StEntry;
        end
      end
      StEntry: begin
        if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = StLocked;
        end else if (key_enter) begin
          buf_d = '0;
          cnt_d = '0;
          if (cnt_full && (buf_q == code_cur)) begin
            state_d = StOpen;
            fail_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FailW'(MAX_TRIES)) begin
              state_d = StAlarm;
              tick_d  = '0;
            end else begin
              state_d = StLocked;
            end
          end
        end else if (key_digit && !cnt_full) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOpen: begin
        if (key_clear) begin
          state_d = StLocked;
`ifdef LOCK_PROGRAM_EN
        end else if (key_prog) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = StProgram;
`endif
        end
      end
`ifdef LOCK_PROGRAM_EN
      StProgram: begin
        if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = StOpen;
        end else if (key_enter) begin
          if (cnt_full) begin
            code_d  = buf_q;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = StOpen;
          end
        end else if (key_digit && !cnt_full) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StAlarm: begin
        // Keys are ignored; leave after exactly LOCKOUT_TICKS cycles in this state.
        if (tick_q == TickW'(LOCKOUT_TICKS - 1)) begin
          state_d = StLocked;
          fail_d  = '0;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StLocked;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q <= StLocked;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      tick_q  <= '0;
`ifdef LOCK_PROGRAM_EN
      code_q  <= CodeInit;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      tick_q  <= tick_d;
`ifdef LOCK_PROGRAM_EN
      code_q  <= code_d;
`endif
    end
  end

  // Outputs decoded from the current state and buffer.
  always_comb begin
    red     = (state_q == StLocked) || (state_q == StEntry) || (state_q == StAlarm);
    green   = (state_q == StOpen);
`ifdef LOCK_PROGRAM_EN
    blue    = (state_q == StProgram) || (state_q == StAlarm);
`else
    blue    = (state_q == StAlarm);
`endif
    left    = 8'(fail_q);
    right   = 8'(cnt_q);
    buf_ext = 32'(buf_q);
    for (int n = 0; n < 8; n++) begin
      ss_arr[n] = 8'h00;
      if (n < int'(cnt_q)) begin
        ss_arr[n] = hex7seg(buf_ext[4*n +: 4]);
      end
    end
  end

  assign ss0 = ss_arr[0];
  assign ss1 = ss_arr[1];
  assign ss2 = ss_arr[2];
  assign ss3 = ss_arr[3];
  assign ss4 = ss_arr[4];
  assign ss5 = ss_arr[5];
  assign ss6 = ss_arr[6];
  assign ss7 = ss_arr[7];

endmodule

// File: tb/tb_lock_gen.sv
// Scoreboard bench for lock_gen: stimulus tasks update a behavioural lock model
// and queue the expected outputs for given cycles; a monitor compares them.
module tb_lock_gen;

  localparam int Len      = 4;
  localparam int MaxTries = 3;
  localparam int Lockout  = 500;

  localparam int MLocked  = 0;
  localparam int MEntry   = 1;
  localparam int MOpen    = 2;
  localparam int MProgram = 3;
  localparam int MAlarm   = 4;

  localparam logic [20:0] KEnter = 21'h10000;
  localparam logic [20:0] KClear = 21'h20000;
  localparam logic [20:0] KProg  = 21'h40000;

  logic        hz100 = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] pb    = '0;
  logic [7:0]  ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0, left, right;
  logic        red, green, blue;

  lock_gen #(
    .CODE_LEN      (Len),
    .CODE_DEFAULT  (32'h0000_1234),
    .MAX_TRIES     (MaxTries),
    .LOCKOUT_TICKS (Lockout)
  ) dut (
    .hz100 (hz100),
    .reset (reset),
    .pb    (pb),
    .ss7   (ss7),
    .ss6   (ss6),
    .ss5   (ss5),
    .ss4   (ss4),
    .ss3   (ss3),
    .ss2   (ss2),
    .ss1   (ss1),
    .ss0   (ss0),
    .left  (left),
    .right (right),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  always #5 hz100 = ~hz100;

  int cyc = 0;
  always @(posedge hz100) cyc++;

  typedef struct {
    int          due;
    logic [63:0] ss;
    logic [7:0]  left;
    logic [7:0]  right;
    logic [2:0]  rgb;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference model: mode, digits typed (oldest first), failures, code.
  int          m_mode;
  int          m_digs[$];
  int          m_fails;
  int          m_alarm_at;
  logic [31:0] m_code;

  function automatic void model_reset();
    m_mode     = MLocked;
    m_digs.delete();
    m_fails    = 0;
    m_alarm_at = 0;
    m_code     = 32'h0000_1234;
  endfunction

  function automatic logic [31:0] digs_value();
    logic [31:0] v = '0;
    foreach (m_digs[i]) v = (v << 4) | 32'(m_digs[i]);
    return v;
  endfunction

  // Lockout holds for Lockout cycles after the edge that entered it.
  function automatic void sync(int t);
    if (m_mode == MAlarm && t >= m_alarm_at + Lockout) begin
      m_mode  = MLocked;
      m_fails = 0;
    end
  endfunction

  function automatic void apply(logic [20:0] keys, int t);
    int k = -1;
    if (keys[17]) k = 17;
    else if (keys[16]) k = 16;
`ifdef LOCK_PROGRAM_EN
    else if (keys[18]) k = 18;
`endif
    else begin
      for (int i = 15; i >= 0; i--) if (keys[i]) k = i;
    end
    if (k < 0) return;
    case (m_mode)
      MLocked: begin
        if (k < 16) begin
          m_digs.delete();
          m_digs.push_back(k);
          m_mode = MEntry;
        end
      end
      MEntry, MProgram: begin
        if (k < 16) begin
          if (m_digs.size() < Len) m_digs.push_back(k);
        end else if (k == 17) begin
          m_digs.delete();
          m_mode = (m_mode == MEntry) ? MLocked : MOpen;
        end else if (k == 16) begin
          if (m_mode == MEntry) begin
            if (m_digs.size() == Len && digs_value() == (m_code & 32'hFFFF)) begin
              m_mode  = MOpen;
              m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails >= MaxTries) begin
                m_mode     = MAlarm;
                m_alarm_at = t;
              end else begin
                m_mode = MLocked;
              end
            end
            m_digs.delete();
          end else if (m_digs.size() == Len) begin
            m_code = digs_value();
            m_digs.delete();
            m_mode = MOpen;
          end
        end
      end
      MOpen: begin
        if (k == 17) m_mode = MLocked;
        else if (k == 18) begin
          m_digs.delete();
          m_mode = MProgram;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t model_out(int due, string name);
    exp_t e;
    e.due   = due;
    e.name  = name;
    e.left  = 8'(m_fails);
    e.right = 8'(m_digs.size());
    case (m_mode)
      MOpen:    e.rgb = 3'b010;
      MProgram: e.rgb = 3'b001;
      MAlarm:   e.rgb = 3'b101;
      default:  e.rgb = 3'b100;
    endcase
    e.ss = '0;
    for (int n = 0; n < m_digs.size(); n++) e.ss[8*n +: 8] = seg_tab[m_digs[m_digs.size()-1-n]];
    return e;
  endfunction

  function automatic void push_exp(exp_t e);
    int i = exp_q.size();
    while (i > 0 && exp_q[i-1].due > e.due) i--;
    exp_q.insert(i, e);
  endfunction

  // Monitor: compares every queued expectation on the falling edge of its cycle.
  always @(negedge hz100) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d skipped (now %0d)", e.name, e.due, cyc);
      end else if ({ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0} !== e.ss || left !== e.left ||
                   right !== e.right || {red, green, blue} !== e.rgb) begin
        errors++;
        $display("FAIL %s @%0d: got ss=%h left=%0d right=%0d rgb=%b, need ss=%h left=%0d right=%0d rgb=%b",
                 e.name, cyc, {ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0}, left, right,
                 {red, green, blue}, e.ss, e.left, e.right, e.rgb);
      end
    end
  end

  // Key is sampled at edge c0 and acts at edge c0+1; outputs checked on both sides.
  task automatic press(input logic [20:0] keys, input int hold, input string name);
    int c0;
    @(negedge hz100);
    pb = keys;
    c0 = cyc + 1;
    sync(c0);
    push_exp(model_out(c0, {name, " (before)"}));
    apply(keys, c0 + 1);
    sync(c0 + 1);
    push_exp(model_out(c0 + 1, name));
    if (hold > 1) push_exp(model_out(c0 + hold, {name, " (held)"}));
    repeat (hold) @(negedge hz100);
    pb = '0;
    repeat (2) @(negedge hz100);
  endtask

  task automatic type_hex(input logic [31:0] val, input int n, input string name);
    for (int i = n - 1; i >= 0; i--) begin
      logic [20:0] k;
      k = '0;
      k[val[4*i +: 4]] = 1'b1;
      press(k, 1, name);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge hz100);
    reset = 1'b1;
    pb    = '0;
    model_reset();
    push_exp(model_out(cyc + 1, {name, " (asserted)"}));
    repeat (2) @(negedge hz100);
    reset = 1'b0;
    push_exp(model_out(cyc + 1, {name, " (released)"}));
    @(negedge hz100);
  endtask

  task automatic wait_alarm_end();
    int t_end;
    t_end = m_alarm_at + Lockout;
    sync(t_end - 1);
    push_exp(model_out(t_end - 1, "alarm last cycle"));
    sync(t_end);
    push_exp(model_out(t_end, "alarm expired"));
    while (cyc < t_end + 1) @(negedge hz100);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge hz100);
    do_reset("power-on reset");

    type_hex(32'h1234, 4, "good digit");
    press(KEnter, 1, "enter good code");
    press(KClear, 1, "relock from open");

    for (int r = 0; r < 3; r++) begin
      type_hex(32'h1235, 4, "bad digit");
      press(KEnter, 1, "enter bad code");
    end
    type_hex(32'h1234, 4, "digit in alarm");
    press(KEnter, 1, "enter in alarm");
    wait_alarm_end();

    type_hex(32'h123456, 6, "overflow digit");
    press(KEnter, 1, "enter after overflow");
    press(KEnter, 1, "enter in open");
    press(21'h00100, 1, "digit in open");
    press(KClear, 1, "relock");

    press(21'h00002, 1, "digit 1");
    press(21'h00004 | KClear, 1, "digit with clear");
    press(KEnter, 1, "enter when empty");
    press(21'h00080, 5, "held digit 7");
    press(21'h00A00 | 21'h180000, 1, "two digits plus unused");
    press(KClear, 1, "clear entry");

    type_hex(32'h0056, 2, "partial digit");
    do_reset("reset mid entry");
    for (int r = 0; r < 3; r++) begin
      type_hex(32'h4321, 4, "bad digit");
      press(KEnter, 1, "enter bad code");
    end
    repeat (100) @(negedge hz100);
    do_reset("reset mid alarm");
    type_hex(32'h1234, 4, "good digit");
    press(KEnter, 1, "open after reset");
    press(KClear, 1, "relock");

`ifdef LOCK_PROGRAM_EN
    type_hex(32'h1234, 4, "good digit");
    press(KEnter, 1, "open for program");
    press(KProg, 1, "program key");
    type_hex(32'h98, 2, "short program digit");
    press(KEnter, 1, "short program enter");
    press(KClear, 1, "abort program");
    press(KProg, 1, "program key again");
    type_hex(32'h9876, 4, "program digit");
    press(KEnter, 1, "store code");
    press(KClear, 1, "relock");
    type_hex(32'h9876, 4, "new code digit");
    press(KEnter, 1, "open with new code");
    press(KClear, 1, "relock");
    type_hex(32'h1234, 4, "old code digit");
    press(KEnter, 1, "old code rejected");
    press(21'h00002 | KProg, 1, "program in locked");
    press(KClear, 1, "clear");
    type_hex(32'h9876, 4, "new code digit");
    press(KEnter, 1, "open again");
    press(KProg, 1, "program key");
    type_hex(32'h55, 2, "partial program digit");
    do_reset("reset mid program");
`endif

    for (int s = 0; s < 60; s++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        type_hex(32'h1234, 4, "rnd good digit");
        press(KEnter, 1, "rnd enter");
      end else if (kind < 7) begin
        int n;
        n = $urandom_range(0, 6);
        for (int i = 0; i < n; i++) begin
          logic [20:0] k;
          k = '0;
          k[$urandom_range(0, 15)] = 1'b1;
          press(k, 1, "rnd digit");
        end
        press(KEnter, 1, "rnd enter");
      end else if (kind == 7) begin
        press(21'($urandom()), 1, "rnd multi key");
      end else begin
        press(KClear, $urandom_range(1, 3), "rnd clear");
      end
      if (m_mode == MAlarm) begin
        press(21'($urandom()), 1, "rnd key in alarm");
        wait_alarm_end();
      end
      if (m_mode == MOpen && $urandom_range(0, 1) == 1) press(KClear, 1, "rnd relock");
    end

    repeat (10) @(negedge hz100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
